// File: rtl/hdmi_test_source_pkg.sv
// Shared types and constants for the hdmi test-pattern and audio test-signal source.
package hdmi_test_source_pkg;

  typedef enum logic [2:0] {
    BANDS    = 3'd0,
    BORDER   = 3'd1,
    BARS     = 3'd2,
    CHECKER  = 3'd3,
    GRADIENT = 3'd4
  } mode_t;

  localparam logic [23:0] COLOUR_BLACK   = 24'h000000;
  localparam logic [23:0] COLOUR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COLOUR_RED     = 24'hFF0000;
  localparam logic [23:0] COLOUR_GREEN   = 24'h00FF00;
  localparam logic [23:0] COLOUR_BLUE    = 24'h0000FF;
  localparam logic [23:0] COLOUR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COLOUR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COLOUR_MAGENTA = 24'hFF00FF;

  // 683/2048 is close enough to 1/3 for any realistic screen height
  localparam int unsigned RECIP3_NUM   = 683;
  localparam int unsigned RECIP3_SHIFT = 11;

  // Requested pattern codes outside the defined set fall back to BANDS
  function automatic mode_t decode_mode(input logic [2:0] sel);
    case (sel)
      3'd0:    return BANDS;
      3'd1:    return BORDER;
      3'd2:    return BARS;
      3'd3:    return CHECKER;
      3'd4:    return GRADIENT;
      default: return BANDS;
    endcase
  endfunction

  // Colour bar order: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COLOUR_WHITE;
      3'd1:    return COLOUR_YELLOW;
      3'd2:    return COLOUR_CYAN;
      3'd3:    return COLOUR_GREEN;
      3'd4:    return COLOUR_MAGENTA;
      3'd5:    return COLOUR_RED;
      3'd6:    return COLOUR_BLUE;
      default: return COLOUR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_test_source_audio_clk_gen.sv
// Fractional audio sample clock: a phase accumulator that toggles clk_audio so that
// exactly AUDIO_RATE rising edges occur every CLK_FRQ_HZ pixel clocks, with no drift.
module audio_clk_gen #(
  parameter int unsigned CLK_FRQ_HZ = 74_250_000,
  parameter int unsigned AUDIO_RATE = 48000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic clk_audio_o,
  output logic fall_o
);

  localparam logic [31:0] STEP   = 32'(2 * AUDIO_RATE);
  localparam logic [31:0] MODULUS = 32'(CLK_FRQ_HZ);

  logic [31:0] acc_q, acc_d, sum;
  logic        toggle;
  logic        clk_audio_q, fall_q;

  // Next accumulator value; a toggle happens whenever the sum crosses the modulus
  always_comb begin
    sum    = acc_q + STEP;
    toggle = (sum >= MODULUS);
    acc_d  = toggle ? (sum - MODULUS) : sum;
  end

  // Accumulator, audio clock and a falling-edge pulse aligned with the clock change
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      clk_audio_q <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fall_q <= toggle && clk_audio_q;
      if (toggle) begin
        clk_audio_q <= ~clk_audio_q;
      end
    end
  end

  assign clk_audio_o = clk_audio_q;
  assign fall_o      = fall_q;

endmodule

// File: rtl/hdmi_test_source.sv
// Video test-pattern and square-wave audio source for the hdmi core (clk_pixel domain).
// Optional feature macro HDMI_TEST_SOURCE_MOTION_EN: checker and gradient scroll with
// frame_count; without it the patterns are static.
module hdmi_test_source
  import hdmi_test_source_pkg::*;
#(
  parameter int                             BIT_WIDTH        = 12,
  parameter int                             BIT_HEIGHT       = 11,
  parameter int unsigned                    CLK_FRQ_HZ       = 74_250_000,
  parameter int unsigned                    AUDIO_RATE       = 48000,
  parameter int                             AUDIO_BIT_WIDTH  = 16,
  parameter int                             TONE_HALF_PERIOD = 24,
  parameter logic [AUDIO_BIT_WIDTH-1:0]     TONE_AMPLITUDE   = 16'h2000,
  parameter int                             CHECK_LOG2       = 5
) (
  input  logic                                 clk_pixel,
  input  logic                                 reset,
  input  logic [BIT_WIDTH-1:0]                 cx,
  input  logic [BIT_HEIGHT-1:0]                cy,
  input  logic [BIT_WIDTH-1:0]                 screen_width,
  input  logic [BIT_HEIGHT-1:0]                screen_height,
  input  logic [2:0]                           mode_sel,
  output logic [2:0]                           mode,
  output logic [15:0]                          frame_count,
  output logic [23:0]                          rgb,
  output logic                                 clk_audio,
  output logic [1:0][AUDIO_BIT_WIDTH-1:0]      audio_sample_word,
  output logic                                 sample_strobe
);

  localparam int PW  = BIT_HEIGHT + 12;
  localparam int TCW = $clog2(TONE_HALF_PERIOD + 1);
  localparam logic [AUDIO_BIT_WIDTH-1:0] AMP_POS = TONE_AMPLITUDE;
  localparam logic [AUDIO_BIT_WIDTH-1:0] AMP_NEG = ~TONE_AMPLITUDE + AUDIO_BIT_WIDTH'(1);
  localparam logic [TCW-1:0]             TONE_LAST = TCW'(TONE_HALF_PERIOD - 1);

  mode_t                  mode_q;
  logic [15:0]            frame_count_q;
  logic [BIT_HEIGHT-1:0]  band1_q, band2_q;
  logic [BIT_WIDTH-1:0]   bar_width_q;
  logic [BIT_WIDTH-1:0]   bar_cnt_q, bar_cnt_d, bar_cnt_cur;
  logic [2:0]             bar_idx_q, bar_idx_d, bar_idx_cur;
  logic [23:0]            rgb_q, rgb_d;
  logic [PW-1:0]          prod1, prod2;
  logic                   frame_start;
  logic [7:0]             motion_off;
  logic [BIT_WIDTH-1:0]   checker_x;
  logic [7:0]             grad_r;

  logic                        audio_fall;
  logic [TCW-1:0]              tone_cnt_q;
  logic                        pol_q;
  logic [AUDIO_BIT_WIDTH-1:0]  left_q, right_q;
  logic                        strobe_q;

  assign frame_start = (cx == '0) && (cy == '0);
  assign prod1       = PW'(screen_height) * PW'(RECIP3_NUM);
  assign prod2       = prod1 << 1;

`ifdef HDMI_TEST_SOURCE_MOTION_EN
  assign motion_off = frame_count_q[7:0];
`else
  assign motion_off = 8'd0;
`endif

  assign checker_x = cx + BIT_WIDTH'(motion_off);
  assign grad_r    = cx[7:0] + motion_off;

  // Per-frame state: pattern selection, frame counter and geometry snapshots
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      mode_q        <= BANDS;
      frame_count_q <= '0;
      band1_q       <= '0;
      band2_q       <= '0;
      bar_width_q   <= '0;
    end else if (frame_start) begin
      mode_q        <= decode_mode(mode_sel);
      frame_count_q <= frame_count_q + 16'd1;
      band1_q       <= BIT_HEIGHT'(prod1 >> RECIP3_SHIFT);
      band2_q       <= BIT_HEIGHT'(prod2 >> RECIP3_SHIFT);
      bar_width_q   <= screen_width >> 3;
    end
  end

  // Colour-bar tracking: counter restarts each line, index steps once per bar width
  always_comb begin
    bar_cnt_cur = (cx == '0) ? '0 : bar_cnt_q;
    bar_idx_cur = (cx == '0) ? 3'd0 : bar_idx_q;
    if (bar_cnt_cur == (bar_width_q - BIT_WIDTH'(1))) begin
      bar_cnt_d = '0;
      bar_idx_d = (bar_idx_cur == 3'd7) ? 3'd7 : (bar_idx_cur + 3'd1);
    end else begin
      bar_cnt_d = bar_cnt_cur + BIT_WIDTH'(1);
      bar_idx_d = bar_idx_cur;
    end
  end

  // Pattern generator for the current pixel
  always_comb begin
    rgb_d = COLOUR_BLACK;
    case (mode_q)
      BANDS: begin
        if (cy < band1_q)      rgb_d = COLOUR_RED;
        else if (cy < band2_q) rgb_d = COLOUR_GREEN;
        else                   rgb_d = COLOUR_BLUE;
      end
      BORDER: begin
        if (cx == '0)                                    rgb_d = COLOUR_RED;
        else if (cy == '0)                               rgb_d = COLOUR_GREEN;
        else if ((cx == (screen_width - BIT_WIDTH'(1))) ||
                 (cy == (screen_height - BIT_HEIGHT'(1)))) rgb_d = COLOUR_BLUE;
        else                                             rgb_d = COLOUR_BLACK;
      end
      BARS:     rgb_d = bar_colour(bar_idx_cur);
      CHECKER:  rgb_d = (checker_x[CHECK_LOG2] ^ cy[CHECK_LOG2]) ? COLOUR_WHITE : COLOUR_BLACK;
      GRADIENT: rgb_d = {grad_r, cy[7:0], 8'h80};
      default:  rgb_d = COLOUR_BLACK;
    endcase
  end

  // Register the pixel colour and the bar tracking state
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      rgb_q     <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      rgb_q     <= rgb_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  audio_clk_gen #(
    .CLK_FRQ_HZ (CLK_FRQ_HZ),
    .AUDIO_RATE (AUDIO_RATE)
  ) u_audio_clk_gen (
    .clk_i       (clk_pixel),
    .rst_i       (reset),
    .clk_audio_o (clk_audio),
    .fall_o      (audio_fall)
  );

  // Square-wave tone: samples change just after the audio clock falls, far from its rise
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      tone_cnt_q <= '0;
      pol_q      <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= audio_fall;
      if (audio_fall) begin
        left_q  <= pol_q ? AMP_NEG : AMP_POS;
        right_q <= pol_q ? AMP_POS : AMP_NEG;
        if (tone_cnt_q == TONE_LAST) begin
          tone_cnt_q <= '0;
          pol_q      <= ~pol_q;
        end else begin
          tone_cnt_q <= tone_cnt_q + TCW'(1);
        end
      end
    end
  end

  assign mode                 = mode_q;
  assign frame_count          = frame_count_q;
  assign rgb                  = rgb_q;
  assign audio_sample_word[1] = right_q;
  assign audio_sample_word[0] = left_q;
  assign sample_strobe        = strobe_q;

endmodule

// File: tb/tb_hdmi_test_source.sv
// Scoreboard bench for hdmi_test_source with a scaled-down audio clock
// (1000 Hz pixel clock, 48 Hz sample rate) so whole audio periods fit in a short run.
module tb_hdmi_test_source;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned RATE   = 48;

  logic              clk_pixel = 1'b0;
  logic              reset;
  logic [11:0]       cx, screen_width;
  logic [10:0]       cy, screen_height;
  logic [2:0]        mode_sel, mode;
  logic [15:0]       frame_count;
  logic [23:0]       rgb;
  logic              clk_audio;
  logic [1:0][15:0]  audio_sample_word;
  logic              sample_strobe;

  typedef struct {
    bit          chk;
    logic [23:0] exp;
    string       name;
  } pix_t;

  pix_t        pixQ[$];
  logic [31:0] audQ[$];
  int          errCount   = 0;
  int          checkCount = 0;
  int          fcModel    = 0;
  int          strobeCnt  = 0;
  bit          audioOn    = 1'b0;
  logic [31:0] lastExp    = '0;
  logic        prevMonA   = 1'b0;
  logic [23:0] barTab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  hdmi_test_source #(
    .BIT_WIDTH        (12),
    .BIT_HEIGHT       (11),
    .CLK_FRQ_HZ       (CLK_HZ),
    .AUDIO_RATE       (RATE),
    .AUDIO_BIT_WIDTH  (16),
    .TONE_HALF_PERIOD (24),
    .TONE_AMPLITUDE   (16'h2000),
    .CHECK_LOG2       (5)
  ) dut (
    .clk_pixel         (clk_pixel),
    .reset             (reset),
    .cx                (cx),
    .cy                (cy),
    .screen_width      (screen_width),
    .screen_height     (screen_height),
    .mode_sel          (mode_sel),
    .mode              (mode),
    .frame_count       (frame_count),
    .rgb               (rgb),
    .clk_audio         (clk_audio),
    .audio_sample_word (audio_sample_word),
    .sample_strobe     (sample_strobe)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] expChecker(input logic [11:0] x, input logic [10:0] y);
    logic [11:0] xs;
    xs = x;
`ifdef HDMI_TEST_SOURCE_MOTION_EN
    xs = x + 12'(fcModel[7:0]);
`endif
    return (xs[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
  endfunction

  function automatic logic [23:0] expGradient(input logic [11:0] x, input logic [10:0] y);
    logic [7:0] r;
    r = x[7:0];
`ifdef HDMI_TEST_SOURCE_MOTION_EN
    r = x[7:0] + fcModel[7:0];
`endif
    return {r, y[7:0], 8'h80};
  endfunction

  // Drive one pixel on the falling edge and queue what rgb must show one cycle later
  task automatic applyStimulus(input logic [11:0] x, input logic [10:0] y, input bit chk,
                               input logic [23:0] exp, input string name);
    pix_t p;
    @(negedge clk_pixel);
    cx = x;
    cy = y;
    p.chk  = chk;
    p.exp  = exp;
    p.name = name;
    pixQ.push_back(p);
    if (x == 12'd0 && y == 11'd0) fcModel++;
  endtask

  task automatic frameStart(input logic [2:0] sel, input logic [2:0] expMode);
    mode_sel = sel;
    applyStimulus(12'd0, 11'd0, 1'b0, 24'h0, "frame_start");
    @(posedge clk_pixel);
    #1;
    checkOutput("mode_latch", {29'd0, mode}, {29'd0, expMode});
    applyStimulus(12'd1, 11'd1, 1'b0, 24'h0, "frame_leave");
  endtask

  // Pixel monitor: every driven pixel has a queue entry, popped after the next edge
  always @(posedge clk_pixel) begin : pixMon
    pix_t p;
    #1;
    if (pixQ.size() > 0) begin
      p = pixQ.pop_front();
      if (p.chk) checkOutput(p.name, {8'd0, rgb}, {8'd0, p.exp});
    end
  end

  // Audio monitor: compare each strobed sample and sample stability at clk_audio rises
  always @(posedge clk_pixel) begin : audMon
    #1;
    if (audioOn) begin
      if (clk_audio && !prevMonA)
        checkOutput("sample_stable_at_rise", audio_sample_word, lastExp);
      prevMonA = clk_audio;
      if (sample_strobe) begin
        strobeCnt++;
        if (audQ.size() == 0) begin
          checkCount++;
          errCount++;
          $display("[TB] FAIL unexpected_strobe: got %h expected no strobe", audio_sample_word);
        end else begin
          lastExp = audQ.pop_front();
          checkOutput("audio_sample", audio_sample_word, lastExp);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : mainSeq
    int rises;
    int waitCnt;
    logic prevA;

    reset         = 1'b1;
    cx            = 12'd5;
    cy            = 11'd5;
    screen_width  = 12'd1280;
    screen_height = 11'd720;
    mode_sel      = 3'd0;
    #3;
    checkOutput("reset_rgb", {8'd0, rgb}, 32'd0);
    checkOutput("reset_mode", {29'd0, mode}, 32'd0);
    checkOutput("reset_frame_count", {16'd0, frame_count}, 32'd0);
    checkOutput("reset_clk_audio", {31'd0, clk_audio}, 32'd0);
    checkOutput("reset_samples", audio_sample_word, 32'd0);
    checkOutput("reset_strobe", {31'd0, sample_strobe}, 32'd0);
    @(negedge clk_pixel);
    reset   = 1'b0;
    fcModel = 0;

    $display("[TB] bands, h=720");
    frameStart(3'd0, 3'd0);
    applyStimulus(12'd5, 11'd239, 1'b1, 24'hFF0000, "bands_239");
    applyStimulus(12'd5, 11'd240, 1'b1, 24'h00FF00, "bands_240");
    applyStimulus(12'd5, 11'd479, 1'b1, 24'h00FF00, "bands_479");
    applyStimulus(12'd5, 11'd480, 1'b1, 24'h0000FF, "bands_480");
    applyStimulus(12'd5, 11'd719, 1'b1, 24'h0000FF, "bands_719");

    $display("[TB] mode change waits for frame start");
    mode_sel = 3'd2;
    applyStimulus(12'd100, 11'd100, 1'b1, 24'hFF0000, "mode_hold_rgb");
    @(posedge clk_pixel);
    #1;
    checkOutput("mode_hold", {29'd0, mode}, 32'd0);
    frameStart(3'd2, 3'd2);

    $display("[TB] colour bars, w=1280");
    for (int i = 0; i < 1280; i++) begin
      applyStimulus(12'(i), 11'd1, ((i % 160) == 0) || ((i % 160) == 159),
                    barTab[(i / 160 > 7) ? 7 : (i / 160)], "bars");
    end

    $display("[TB] border");
    frameStart(3'd1, 3'd1);
    applyStimulus(12'd0,    11'd5,   1'b1, 24'hFF0000, "border_left");
    applyStimulus(12'd5,    11'd0,   1'b1, 24'h00FF00, "border_top");
    applyStimulus(12'd1279, 11'd0,   1'b1, 24'h00FF00, "border_top_over_right");
    applyStimulus(12'd1279, 11'd5,   1'b1, 24'h0000FF, "border_right");
    applyStimulus(12'd5,    11'd719, 1'b1, 24'h0000FF, "border_bottom");
    applyStimulus(12'd5,    11'd5,   1'b1, 24'h000000, "border_inside");

    $display("[TB] checker over two frames");
    for (int f = 0; f < 2; f++) begin
      frameStart(3'd3, 3'd3);
      applyStimulus(12'd31,  11'd1,  1'b1, expChecker(12'd31, 11'd1),   "checker_31_1");
      applyStimulus(12'd32,  11'd1,  1'b1, expChecker(12'd32, 11'd1),   "checker_32_1");
      applyStimulus(12'd32,  11'd32, 1'b1, expChecker(12'd32, 11'd32),  "checker_32_32");
      applyStimulus(12'd0,   11'd32, 1'b1, expChecker(12'd0, 11'd32),   "checker_0_32");
      applyStimulus(12'd100, 11'd40, 1'b1, expChecker(12'd100, 11'd40), "checker_100_40");
    end

    $display("[TB] gradient");
    frameStart(3'd4, 3'd4);
    applyStimulus(12'h123, 11'h045, 1'b1, expGradient(12'h123, 11'h045), "gradient_a");
    applyStimulus(12'h0FF, 11'h7FF, 1'b1, expGradient(12'h0FF, 11'h7FF), "gradient_b");

    $display("[TB] out-of-range mode requests");
    frameStart(3'd6, 3'd0);
    frameStart(3'd7, 3'd0);
    frameStart(3'd5, 3'd0);
    applyStimulus(12'd5, 11'd300, 1'b1, 24'h00FF00, "bands_after_bad_sel");
    @(posedge clk_pixel);
    #1;
    checkOutput("frame_count", {16'd0, frame_count}, 32'(fcModel));

    $display("[TB] audio clock and tone");
    reset    = 1'b1;
    cx       = 12'd0;
    cy       = 11'd0;
    mode_sel = 3'd4;
    for (int k = 0; k < 100; k++) begin
      if (((k / 24) % 2) == 0) audQ.push_back(32'hE000_2000);
      else                     audQ.push_back(32'h2000_E000);
    end
    lastExp  = '0;
    prevMonA = 1'b0;
    audioOn  = 1'b1;
    @(negedge clk_pixel);
    reset   = 1'b0;
    fcModel = 1;
    rises   = 0;
    prevA   = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      @(posedge clk_pixel);
      #1;
      if (clk_audio && !prevA && i < 1000) rises++;
      prevA = clk_audio;
      if (i == 0) begin
        cx = 12'd10;
        cy = 11'd10;
      end
    end
    checkOutput("audio_rises_per_window", 32'(rises), 32'd48);
    checkOutput("audio_strobe_count", 32'(strobeCnt), 32'd100);
    checkOutput("audio_queue_drained", 32'(audQ.size()), 32'd0);

    $display("[TB] reset while clk_audio high");
    waitCnt = 0;
    while (clk_audio !== 1'b1 && waitCnt < 40) begin
      @(posedge clk_pixel);
      #1;
      waitCnt++;
    end
    checkOutput("wait_clk_audio_high", {31'd0, clk_audio}, 32'd1);
    checkOutput("pre_reset_mode", {29'd0, mode}, 32'd4);
    checkOutput("pre_reset_frame_count", {16'd0, frame_count}, 32'd1);
    checkOutput("pre_reset_rgb", {8'd0, rgb}, {8'd0, expGradient(12'd10, 11'd10)});
    audioOn = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_rgb", {8'd0, rgb}, 32'd0);
    checkOutput("mid_reset_mode", {29'd0, mode}, 32'd0);
    checkOutput("mid_reset_frame_count", {16'd0, frame_count}, 32'd0);
    checkOutput("mid_reset_clk_audio", {31'd0, clk_audio}, 32'd0);
    checkOutput("mid_reset_samples", audio_sample_word, 32'd0);
    checkOutput("mid_reset_strobe", {31'd0, sample_strobe}, 32'd0);
    @(negedge clk_pixel);
    reset = 1'b0;
    repeat (2) @(posedge clk_pixel);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
